// File: rtl/alu_pkg.sv
// Shared opcode constants and the flag bundle for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_PASS_S = 4'h0;
  localparam logic [3:0] OP_PASS_R = 4'h1;
  localparam logic [3:0] OP_INC    = 4'h2;
  localparam logic [3:0] OP_DEC    = 4'h3;
  localparam logic [3:0] OP_ADD    = 4'h4;
  localparam logic [3:0] OP_SUB    = 4'h5;
  localparam logic [3:0] OP_LSR    = 4'h6;
  localparam logic [3:0] OP_LSL    = 4'h7;
  localparam logic [3:0] OP_AND    = 4'h8;
  localparam logic [3:0] OP_OR     = 4'h9;
  localparam logic [3:0] OP_XOR    = 4'hA;
  localparam logic [3:0] OP_NOT    = 4'hB;
  localparam logic [3:0] OP_NEG    = 4'hC;
  localparam logic [3:0] OP_ADC    = 4'hD;
  localparam logic [3:0] OP_ASR    = 4'hE;
  localparam logic [3:0] OP_ROR    = 4'hF;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result handshake bundle between a producer, the ALU pipe and a consumer.
interface alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] S;
  logic [3:0]       Alu_Op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             N;
  logic             Z;
  logic             C;
  logic             V;

  modport master (
    output in_valid, R, S, Alu_Op, out_ready,
    input  in_ready, out_valid, Y, N, Z, C, V
  );

  modport slave (
    input  in_valid, R, S, Alu_Op, out_ready,
    output in_ready, out_valid, Y, N, Z, C, V
  );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: result and NZCV flags from operands, opcode and carry-in.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  input  logic [3:0]       Alu_Op,
  input  logic             CF,
  output logic [WIDTH-1:0] Y,
  output alu_flags_t       flags
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  // Signed overflow of a+b: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic y_msb);
    return (a_msb == b_msb) && (y_msb != a_msb);
  endfunction

  // Signed overflow of a-b: operands differ in sign, result sign differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic y_msb);
    return (a_msb != b_msb) && (y_msb != a_msb);
  endfunction

  logic signed [WIDTH-1:0] s_sgn;
  logic        [WIDTH:0]   r_x;
  logic        [WIDTH:0]   s_x;
  logic        [WIDTH:0]   ext;
  logic        [WIDTH-1:0] y;
  logic                    c;
  logic                    v;

  assign s_sgn = $signed(S);
  assign r_x   = {1'b0, R};
  assign s_x   = {1'b0, S};

  // Opcode decode; arithmetic is carried one bit wide so the top bit is carry/borrow.
  always_comb begin
    ext = '0;
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (Alu_Op)
      OP_PASS_S: y = S;
      OP_PASS_R: y = R;
      OP_INC: begin
        ext = s_x + ONE;
        y   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = add_ovf(S[WIDTH-1], 1'b0, ext[WIDTH-1]);
      end
      OP_DEC: begin
        ext = s_x - ONE;
        y   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = sub_ovf(S[WIDTH-1], 1'b0, ext[WIDTH-1]);
      end
      OP_ADD: begin
        ext = r_x + s_x;
        y   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = add_ovf(R[WIDTH-1], S[WIDTH-1], ext[WIDTH-1]);
      end
      OP_SUB: begin
        ext = r_x - s_x;
        y   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = sub_ovf(R[WIDTH-1], S[WIDTH-1], ext[WIDTH-1]);
      end
      OP_LSR: begin
        y = S >> 1;
        c = S[0];
      end
      OP_LSL: begin
        y = S << 1;
        c = S[WIDTH-1];
      end
      OP_AND: y = R & S;
      OP_OR:  y = R | S;
      OP_XOR: y = R ^ S;
      OP_NOT: y = ~S;
      OP_NEG: begin
        // 0-S overflows only for the most-negative S.
        ext = '0 - s_x;
        y   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = sub_ovf(1'b0, S[WIDTH-1], ext[WIDTH-1]);
      end
      OP_ADC: begin
        ext = r_x + s_x + {{WIDTH{1'b0}}, CF};
        y   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = add_ovf(R[WIDTH-1], S[WIDTH-1], ext[WIDTH-1]);
      end
      OP_ASR: begin
        y = s_sgn >>> 1;
        c = S[0];
      end
      OP_ROR: begin
        y = {S[0], S[WIDTH-1:1]};
        c = S[0];
      end
      default: y = '0;
    endcase
  end

  assign Y       = y;
  assign flags.n = y[WIDTH-1];
  assign flags.z = (y == '0);
  assign flags.c = c;
  assign flags.v = v;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline: stage A latches operands, stage B latches result and flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter bit CF_INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  alu_if.slave bus
);

  logic             adv;
  logic             in_rdy;
  logic             acc;

  logic             vld_p0_q, vld_p0_d;
  logic [WIDTH-1:0] r_p0_q,   r_p0_d;
  logic [WIDTH-1:0] s_p0_q,   s_p0_d;
  logic [3:0]       op_p0_q,  op_p0_d;

  logic             vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0] y_p1_q,   y_p1_d;
  alu_flags_t       flg_p1_q, flg_p1_d;
  logic             cf_q,     cf_d;

  logic [WIDTH-1:0] core_y;
  alu_flags_t       core_flg;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .R      (r_p0_q),
    .S      (s_p0_q),
    .Alu_Op (op_p0_q),
    .CF     (cf_q),
    .Y      (core_y),
    .flags  (core_flg)
  );

  // Handshake and next-state for both stages; in_ready never looks at in_valid.
  always_comb begin
    adv    = !vld_p1_q || bus.out_ready;
    in_rdy = !vld_p0_q || adv;
    acc    = bus.in_valid && in_rdy;

    vld_p0_d = vld_p0_q;
    r_p0_d   = r_p0_q;
    s_p0_d   = s_p0_q;
    op_p0_d  = op_p0_q;
    if (acc) begin
      vld_p0_d = 1'b1;
      r_p0_d   = bus.R;
      s_p0_d   = bus.S;
      op_p0_d  = bus.Alu_Op;
    end else if (adv) begin
      vld_p0_d = 1'b0;
    end

    // Stage A -> B: CF follows every transferred op so ADC chains see the prior carry.
    vld_p1_d = vld_p1_q;
    y_p1_d   = y_p1_q;
    flg_p1_d = flg_p1_q;
    cf_d     = cf_q;
    if (adv) begin
      vld_p1_d = vld_p0_q;
      if (vld_p0_q) begin
        y_p1_d   = core_y;
        flg_p1_d = core_flg;
        cf_d     = core_flg.c;
      end
    end
  end

  // Stage A operand registers: qualified by vld_p0_q, so they carry no reset.
  always_ff @(posedge clk) begin
    r_p0_q  <= r_p0_d;
    s_p0_q  <= s_p0_d;
    op_p0_q <= op_p0_d;
  end

  // Valids, visible result, flags and carry flag; reset discards in-flight ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      y_p1_q   <= '0;
      flg_p1_q <= '0;
      cf_q     <= CF_INIT;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      y_p1_q   <= y_p1_d;
      flg_p1_q <= flg_p1_d;
      cf_q     <= cf_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_p1_q;
  assign bus.Y         = y_p1_q;
  assign bus.N         = flg_p1_q.n;
  assign bus.Z         = flg_p1_q.z;
  assign bus.C         = flg_p1_q.c;
  assign bus.V         = flg_p1_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed literal cases, stall/reset scenarios, randomized stream vs model.
module tb_alu_pipe;

  localparam int W       = 16;
  localparam bit CF_INIT = 1'b0;

  localparam longint MASK = (64'sd1 <<< W) - 1;
  localparam longint SMAX = (64'sd1 <<< (W - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (W - 1));

  typedef struct {
    logic [W-1:0] y;
    logic [3:0]   f;  // {N,Z,C,V}
  } exp_t;

  logic clk;
  logic reset;
  int   rdy_mode;   // 0: out_ready=1, 1: random, 2: out_ready=0
  int   n_cmp;
  int   n_fail;
  int   ready_low_cnt;
  logic mcf;

  exp_t         q[$];
  logic [W-1:0] y_log[$];
  logic [3:0]   f_log[$];

  alu_if #(.WIDTH(W)) bus ();

  alu_pipe #(
    .WIDTH   (W),
    .CF_INIT (CF_INIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: result and flags from the opcode table using plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] r,
                                 input logic [W-1:0] s, input logic cf);
    exp_t   e;
    longint ur, us, sr, ss, y, t;
    logic   c, v;
    ur = longint'(r);
    us = longint'(s);
    sr = longint'($signed(r));
    ss = longint'($signed(s));
    c  = 1'b0;
    v  = 1'b0;
    y  = 0;
    case (op)
      4'h0: y = us;
      4'h1: y = ur;
      4'h2: begin y = us + 1; c = (y > MASK); t = ss + 1; v = (t > SMAX); end
      4'h3: begin y = us - 1; c = (us == 0); t = ss - 1; v = (t < SMIN); end
      4'h4: begin y = ur + us; c = (y > MASK); t = sr + ss; v = (t > SMAX) || (t < SMIN); end
      4'h5: begin y = ur - us; c = (ur < us); t = sr - ss; v = (t > SMAX) || (t < SMIN); end
      4'h6: begin y = us >> 1; c = us[0]; end
      4'h7: begin y = us << 1; c = us[W-1]; end
      4'h8: y = ur & us;
      4'h9: y = ur | us;
      4'hA: y = ur ^ us;
      4'hB: y = ~us;
      4'hC: begin y = -us; c = (us != 0); t = -ss; v = (t > SMAX); end
      4'hD: begin
        y = ur + us + longint'(cf);
        c = (y > MASK);
        t = sr + ss + longint'(cf);
        v = (t > SMAX) || (t < SMIN);
      end
      4'hE: begin y = ss >>> 1; c = us[0]; end
      default: begin y = (us >> 1) | (longint'(us[0]) << (W - 1)); c = us[0]; end
    endcase
    y   = y & MASK;
    e.y = y[W-1:0];
    e.f = {e.y[W-1], (y == 0), c, v};
    return e;
  endfunction

  // Consumer-side ready pattern, changed just after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Single compare process: scoreboard of accepted ops, checked every falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      mcf = CF_INIT;
      check("rst_out_valid", bus.out_valid, 0);
    end else begin
      check("in_ready", bus.in_ready, longint'((q.size() < 2) || bus.out_ready));
      if (!bus.in_ready) ready_low_cnt++;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", bus.out_valid, 0);
        end else begin
          e = q[0];
          check("Y", bus.Y, e.y);
          check("NZCV", {bus.N, bus.Z, bus.C, bus.V}, e.f);
          if (bus.out_ready) begin
            void'(q.pop_front());
            y_log.push_back(bus.Y);
            f_log.push_back({bus.N, bus.Z, bus.C, bus.V});
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.Alu_Op, bus.R, bus.S, mcf);
        q.push_back(e);
        mcf = e.f[1];
      end
    end
  end

  // Present one op (called just after a rising edge) and hold it until accepted.
  task automatic send(input logic [3:0] op, input logic [W-1:0] r, input logic [W-1:0] s);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.Alu_Op   = op;
    bus.R        = r;
    bus.S        = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("drain_pending", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input int idx, input logic [W-1:0] y,
                           input logic [3:0] f);
    if (y_log.size() > idx) begin
      check({name, "_Y"}, y_log[idx], y);
      check({name, "_NZCV"}, f_log[idx], f);
    end else begin
      check({name, "_missing"}, y_log.size(), idx + 1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int low0;
    n_cmp         = 0;
    n_fail        = 0;
    ready_low_cnt = 0;
    rdy_mode      = 0;
    mcf           = CF_INIT;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.R         = '0;
    bus.S         = '0;
    bus.Alu_Op    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_Y", bus.Y, 0);
    check("reset_NZCV", {bus.N, bus.Z, bus.C, bus.V}, 0);
    @(posedge clk);
    #1;

    // Add with carry-out, with two-cycle latency check.
    idx = y_log.size();
    send(4'h4, 16'hFFFF, 16'h0001);
    @(negedge clk);
    check("latency_cycle1_out_valid", bus.out_valid, 0);
    @(negedge clk);
    check("latency_cycle2_out_valid", bus.out_valid, 1);
    drain();
    check_log("add_carry", idx, 16'h0000, 4'b0110);

    // ADC back-to-back sees the carry just produced.
    idx = y_log.size();
    send(4'h4, 16'hFFFF, 16'h0001);
    send(4'hD, 16'h0000, 16'h0000);
    drain();
    check_log("adc_chain", idx + 1, 16'h0001, 4'b0000);

    // Signed overflow cases.
    idx = y_log.size();
    send(4'h5, 16'h8000, 16'h0001);
    send(4'hC, 16'h0000, 16'h8000);
    drain();
    check_log("sub_ovf", idx, 16'h7FFF, 4'b0001);
    check_log("neg_min", idx + 1, 16'h8000, 4'b1011);

    // Arithmetic shift and rotate.
    idx = y_log.size();
    send(4'hE, 16'h0000, 16'h8001);
    send(4'hF, 16'h0000, 16'h0001);
    drain();
    check_log("asr", idx, 16'hC000, 4'b1010);
    check_log("ror", idx + 1, 16'h8000, 4'b1010);

    // Stream of 8 with the consumer stalled mid-stream.
    idx  = y_log.size();
    low0 = ready_low_cnt;
    fork
      begin
        for (int k = 0; k < 8; k++) send(4'h1, 16'(k + 1), 16'h0000);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    drain();
    check("stall_in_ready_dropped", (ready_low_cnt > low0), 1);
    check("stream_count", y_log.size() - idx, 8);
    for (int k = 0; k < 8; k++) check_log("stream_order", idx + k, 16'(k + 1), 4'b0000);

    // Reset with two ops in flight.
    send(4'h1, 16'h1111, 16'h0000);
    send(4'h4, 16'hFFFF, 16'h0001);
    check("pre_reset_out_valid", bus.out_valid, 1);
    reset = 1'b1;
    #1;
    check("async_reset_out_valid", bus.out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idx = y_log.size();
    repeat (5) @(posedge clk);
    #1;
    check("no_stale_result", y_log.size() - idx, 0);
    send(4'hD, 16'h0000, 16'h0000);
    drain();
    check_log("cf_after_reset", idx, {{(W-1){1'b0}}, CF_INIT}, {1'b0, !CF_INIT, 2'b00});

    // Randomized stream with random consumer stalls and input gaps.
    rdy_mode = 1;
    for (int k = 0; k < 400; k++) begin
      logic [3:0]   op;
      logic [W-1:0] r;
      logic [W-1:0] s;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       r = 16'hFFFF;
        1:       r = 16'h8000;
        2:       r = 16'h7FFF;
        default: r = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       s = 16'h0000;
        1:       s = 16'h8000;
        2:       s = 16'h0001;
        default: s = 16'($urandom);
      endcase
      send(op, r, s);
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
